// File: rtl/cycle_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cycle_sequencer_pkg
// Shared CPU parameters for the instruction sequencer: the state enumeration,
// the HALT opcode, the active level of the reset pushbutton path and the
// default fetch timeout. The sequencer and its saturating counter import this.
// -----------------------------------------------------------------------------
package cycle_sequencer_pkg;

    // Opcode that stops sequencing until run sees a fresh rising edge.
    localparam logic [5:0] HALT_OP = 6'h3F;

    // Active level of isResetN (the board pushbutton is inverted onto it).
    localparam logic RESET = 1'b0;

    // Default number of memReady-low FETCH cycles tolerated before FAULT.
    localparam int TIMEOUT_CYCLES_DEFAULT = 15;

    // Width of the FETCH wait counter and of the retired-instruction count.
    localparam int WAIT_CNT_WIDTH = 4;
    localparam int RETIRED_WIDTH  = 16;

    // Encodings are visible on the debug port, so they are fixed here.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5,
        ST_FAULT     = 3'd6
    } seq_state_t;

endpackage

// File: rtl/cycle_sequencer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, loads RESET_VALUE
//   en     - count enable, one increment per enabled cycle
//   count  - current count
// -----------------------------------------------------------------------------
module sat_counter
    import cycle_sequencer_pkg::*;
#(
    parameter int               WIDTH       = RETIRED_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RESET) begin
            count_reg <= RESET_VALUE;
        end else if (en && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/cycle_sequencer.sv
// -----------------------------------------------------------------------------
// cycle_sequencer
// Multi-cycle instruction sequencer: IDLE -> FETCH -> DECODE -> EXECUTE ->
// WRITEBACK, with HALT (resumed by a rising edge of run) and a sticky FAULT
// entered when instruction memory fails to answer within TIMEOUT_CYCLES.
// Ports:
//   clock          - rising-edge system clock
//   isResetN       - asynchronous active-low reset
//   run            - level enable for sequencing
//   opCode         - decoded opcode from the parser
//   isALU          - current opcode writes a register
//   memReady       - instruction memory data valid
//   memReq         - fetch request (Moore, FETCH)
//   irLoad         - capture-instruction strobe (Mealy, FETCH && memReady)
//   pcEnable       - PC advance strobe (WRITEBACK)
//   regWriteEnable - register-file write strobe (WRITEBACK && isALU)
//   halted         - in HALT
//   fault          - sticky fetch-timeout flag (FAULT)
//   state          - state encoding for debug monitors
//   retired        - saturating count of retired instructions
// -----------------------------------------------------------------------------
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter int   PC_WIDTH            = 8,
    parameter int   OPCODE_WIDTH        = 6,
    parameter int   TIMEOUT_CYCLES      = TIMEOUT_CYCLES_DEFAULT,
    // Reset value of the retired count; 0 in every normal build.
    parameter logic [RETIRED_WIDTH-1:0] RETIRED_RESET_VALUE = '0
) (
    input  logic                     clock,
    input  logic                     isResetN,
    input  logic                     run,
    input  logic [OPCODE_WIDTH-1:0]  opCode,
    input  logic                     isALU,
    input  logic                     memReady,
    output logic                     memReq,
    output logic                     irLoad,
    output logic                     pcEnable,
    output logic                     regWriteEnable,
    output logic                     halted,
    output logic                     fault,
    output logic [2:0]               state,
    output logic [RETIRED_WIDTH-1:0] retired
);

    // The PC block owns the fetch address; the sequencer only strobes it.
    // An empty guard keeps the parameter attached to this interface.
    generate
        if (PC_WIDTH < 1) begin : g_pc_width_invalid
        end
    endgenerate

    // FAULT is taken on the edge that would make the wait count reach
    // TIMEOUT_CYCLES, i.e. while the counter still holds TIMEOUT_CYCLES-1.
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST =
        WAIT_CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [OPCODE_WIDTH-1:0] HALT_CODE = OPCODE_WIDTH'(HALT_OP);

    seq_state_t                state_reg;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_reg;
    logic                      run_prev_reg;

    always_ff @(posedge clock or negedge isResetN) begin
        if (isResetN == RESET) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            run_prev_reg <= 1'b0;
        end else begin
            run_prev_reg <= run;
            case (state_reg)
                ST_IDLE: begin
                    if (run) begin
                        state_reg    <= ST_FETCH;
                        wait_cnt_reg <= '0;
                    end
                end
                ST_FETCH: begin
                    // memReady wins over a coincident timeout.
                    if (memReady) begin
                        state_reg <= ST_DECODE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_CNT_WIDTH'(1);
                        if (wait_cnt_reg == WAIT_LAST) begin
                            state_reg <= ST_FAULT;
                        end
                    end
                end
                ST_DECODE: begin
                    state_reg <= (opCode == HALT_CODE) ? ST_HALT : ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    state_reg <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    // run is only sampled at instruction boundaries, so a
                    // mid-instruction drop still completes the instruction.
                    if (run) begin
                        state_reg    <= ST_FETCH;
                        wait_cnt_reg <= '0;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    if (run && !run_prev_reg) begin
                        state_reg    <= ST_FETCH;
                        wait_cnt_reg <= '0;
                    end
                end
                ST_FAULT: begin
                    state_reg <= ST_FAULT;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded straight from the state register.
    assign memReq = (state_reg == ST_FETCH);
    assign halted = (state_reg == ST_HALT);
    assign fault  = (state_reg == ST_FAULT);
    assign state  = state_reg;

    // Strobes: each state lasts one cycle where they fire, so they are
    // single-cycle pulses by construction.
    assign irLoad         = (state_reg == ST_FETCH) && memReady;
    assign pcEnable       = (state_reg == ST_WRITEBACK);
    assign regWriteEnable = (state_reg == ST_WRITEBACK) && isALU;

    sat_counter #(
        .WIDTH       (RETIRED_WIDTH),
        .RESET_VALUE (RETIRED_RESET_VALUE)
    ) u_retired (
        .clk   (clock),
        .rst_n (isResetN),
        .en    (state_reg == ST_WRITEBACK),
        .count (retired)
    );

endmodule

// File: tb/tb_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cycle_sequencer
// Directed stimulus with a behavioural model; a second instance starts its
// retired count just below all-ones to exercise saturation.
// -----------------------------------------------------------------------------
module tb_cycle_sequencer;
    import cycle_sequencer_pkg::*;

    localparam int TIMEOUT = 15;
    localparam logic [5:0] OP_ADD = 6'h01;
    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3,
                   P_WB = 4, P_HALT = 5, P_FAULT = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [5:0]  opCode = OP_ADD;
    logic        isALU = 1'b0;
    logic        memReady = 1'b0;

    logic        memReq, irLoad, pcEnable, regWriteEnable, halted, fault;
    logic [2:0]  state;
    logic [15:0] retired;
    logic        s_memReq, s_irLoad, s_pcEnable, s_regWriteEnable, s_halted, s_fault;
    logic [2:0]  s_state;
    logic [15:0] s_retired;

    int n_vec = 0;
    int n_bad = 0;
    bit checking = 0;

    always #5 clk = ~clk;

    cycle_sequencer #(.PC_WIDTH(8), .OPCODE_WIDTH(6), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock(clk), .isResetN(rst_n), .run(run), .opCode(opCode), .isALU(isALU),
        .memReady(memReady), .memReq(memReq), .irLoad(irLoad), .pcEnable(pcEnable),
        .regWriteEnable(regWriteEnable), .halted(halted), .fault(fault),
        .state(state), .retired(retired)
    );

    cycle_sequencer #(.PC_WIDTH(8), .OPCODE_WIDTH(6), .TIMEOUT_CYCLES(TIMEOUT),
                      .RETIRED_RESET_VALUE(16'hFFFD)) dut_sat (
        .clock(clk), .isResetN(rst_n), .run(run), .opCode(opCode), .isALU(isALU),
        .memReady(memReady), .memReq(s_memReq), .irLoad(s_irLoad), .pcEnable(s_pcEnable),
        .regWriteEnable(s_regWriteEnable), .halted(s_halted), .fault(s_fault),
        .state(s_state), .retired(s_retired)
    );

    // ---------------- behavioural model ----------------
    int m_phase;
    int m_waited;
    bit m_run_last;
    int m_retired;
    int m_retired_sat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= P_IDLE;
            m_waited <= 0;
            m_run_last <= 1'b0;
            m_retired <= 0;
            m_retired_sat <= 65533;
        end else begin
            m_run_last <= run;
            if (m_phase == P_WB) begin
                m_retired     <= (m_retired + 1 > 65535) ? 65535 : m_retired + 1;
                m_retired_sat <= (m_retired_sat + 1 > 65535) ? 65535 : m_retired_sat + 1;
            end
            case (m_phase)
                P_IDLE:   if (run) begin m_phase <= P_FETCH; m_waited <= 0; end
                P_FETCH: begin
                    if (memReady) m_phase <= P_DECODE;
                    else begin
                        m_waited <= m_waited + 1;
                        if (m_waited + 1 >= TIMEOUT) m_phase <= P_FAULT;
                    end
                end
                P_DECODE: m_phase <= (opCode == HALT_OP) ? P_HALT : P_EXEC;
                P_EXEC:   m_phase <= P_WB;
                P_WB: begin
                    m_phase <= run ? P_FETCH : P_IDLE;
                    m_waited <= 0;
                end
                P_HALT:   if (run && !m_run_last) begin m_phase <= P_FETCH; m_waited <= 0; end
                default:  m_phase <= m_phase;
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (checking) begin
            logic [40:0] act_v, exp_v;
            act_v = {state, memReq, irLoad, pcEnable, regWriteEnable, halted, fault,
                     retired, s_retired};
            exp_v = {3'(m_phase), m_phase == P_FETCH, (m_phase == P_FETCH) && memReady,
                     m_phase == P_WB, (m_phase == P_WB) && isALU, m_phase == P_HALT,
                     m_phase == P_FAULT, 16'(m_retired), 16'(m_retired_sat)};
            check("cycle {state,memReq,irLoad,pcEn,regWe,halted,fault,retired,sat_retired}",
                  64'(act_v), 64'(exp_v));
            $display("cycle t=%0t state=%0d memReq=%b irLoad=%b pcEn=%b regWe=%b halted=%b fault=%b retired=%h",
                     $time, state, memReq, irLoad, pcEnable, regWriteEnable, halted, fault, retired);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int exp_s1[12] = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 3, 4};

    initial begin
        // Reset state
        repeat (2) step();
        checking = 1;
        check("reset_state", 64'(state), 64'd0);
        check("reset_memReq", 64'(memReq), 64'd0);
        check("reset_retired", 64'(retired), 64'd0);
        check("reset_fault", 64'(fault), 64'd0);
        rst_n = 1'b1;
        repeat (3) begin
            step();
            check("idle_without_run", 64'(state), 64'd0);
        end

        // Back-to-back ALU instructions with an always-ready memory
        run = 1'b1; memReady = 1'b1; isALU = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("s1_state", 64'(state), 64'(exp_s1[i]));
            check("s1_pcEnable", 64'(pcEnable), (i % 4 == 3) ? 64'd1 : 64'd0);
        end
        step();
        check("s1_retired_after_three", 64'(retired), 64'd3);

        // run dropped during EXECUTE still completes the instruction
        step();
        check("drop_decode", 64'(state), 64'd2);
        isALU = 1'b0;
        step();
        check("drop_execute", 64'(state), 64'd3);
        run = 1'b0;
        step();
        check("drop_wb_pcEnable", 64'(pcEnable), 64'd1);
        check("drop_wb_regWe", 64'(regWriteEnable), 64'd0);
        step();
        check("drop_then_idle", 64'(state), 64'd0);
        check("drop_retired", 64'(retired), 64'd4);

        // Fetch timeout: 15 memReady-low FETCH cycles
        memReady = 1'b0; run = 1'b1;
        step();
        check("timeout_fetch_entry", 64'(memReq), 64'd1);
        repeat (14) step();
        check("timeout_edge15_still_fetch", 64'(state), 64'd1);
        step();
        check("timeout_edge16_state", 64'(state), 64'd6);
        check("timeout_edge16_fault", 64'(fault), 64'd1);
        run = 1'b0; step(); run = 1'b1; step(); step();
        memReady = 1'b1; step();
        check("fault_sticky_state", 64'(state), 64'd6);
        check("fault_no_strobe", 64'(irLoad), 64'd0);
        #1 rst_n = 1'b0;
        #1 check("fault_async_clear", 64'(fault), 64'd0);
        step();
        rst_n = 1'b1;

        // memReady on the 15th wait cycle beats the timeout
        run = 1'b1; memReady = 1'b0; isALU = 1'b1;
        step();
        repeat (14) step();
        check("late_ready_still_fetch", 64'(state), 64'd1);
        memReady = 1'b1;
        #1 check("late_ready_irLoad", 64'(irLoad), 64'd1);
        step();
        check("late_ready_decode", 64'(state), 64'd2);
        check("late_ready_no_fault", 64'(fault), 64'd0);

        // HALT instruction, resumed by a run rising edge
        opCode = HALT_OP;
        step();
        check("halt_entered", 64'(halted), 64'd1);
        repeat (5) step();
        check("halt_held", 64'(state), 64'd5);
        run = 1'b0; step();
        check("halt_run_low", 64'(state), 64'd5);
        run = 1'b1; memReady = 1'b0; opCode = OP_ADD;
        step();
        check("halt_resume_fetch", 64'(state), 64'd1);
        check("halt_not_retired", 64'(retired), 64'd0);

        // Asynchronous reset in the middle of FETCH
        #1 rst_n = 1'b0;
        #1 check("async_reset_memReq", 64'(memReq), 64'd0);
        check("async_reset_state", 64'(state), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Saturation on the preloaded instance
        run = 1'b1; memReady = 1'b1; isALU = 1'b1;
        repeat (13) step();
        check("sat_reaches_ffff", 64'(s_retired), 64'hFFFF);
        check("sat_main_retired", 64'(retired), 64'd3);
        run = 1'b0;
        repeat (4) step();
        check("sat_no_wrap", 64'(s_retired), 64'hFFFF);
        check("sat_final_idle", 64'(state), 64'd0);

        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
